// File: rtl/oric_ram_pkg.sv
// Shared types for the Oric system RAM arbiter: FSM state encoding and the
// write-request record (address + data) sized for the default 64K x 8 array.
package oric_ram_pkg;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 8;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } ram_state_t;

    typedef struct packed {
        logic [DEF_AW-1:0] addr;
        logic [DEF_DW-1:0] data;
    } ram_wr_t;

endpackage

// File: rtl/oric_ram_core.sv
// Single-port synchronous array: one write or one read per clock.
// rdata is a registered read port that can also be loaded with a fixed value
// (used while the array is being cleared) and is zeroed by reset.
module oric_ram_core #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          ld,
    input  logic [DW-1:0] ld_val,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    // Array write port.
    // NOTE: the storage array has no reset; a reset loop over every word would
    // not map onto block RAM, and the clear sequence initialises it instead.
    always_ff @(posedge clk_sys) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read data; holds its value in any cycle without a read.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rdata <= '0;
        end else if (ld) begin
            rdata <= ld_val;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/oric_ram_arb.sv
// Oric system RAM with a CPU/video port (A), a loader port (B), a hardware
// clear after reset, a one-entry deferral buffer for port-B writes that
// collide with port A, and a commit acknowledge for port B.
// Optional feature macro: RAM_COLLIDE_EN adds the collide_cnt output, a
// saturating count of cycles in which a port-B write was deferred or dropped.
module oric_ram_arb
    import oric_ram_pkg::*;
#(
    parameter int              AW           = 16,
    parameter int              DW           = 8,
    parameter logic [DW-1:0]   CLR_VAL      = DW'('hFF),
    parameter bit              CLR_ON_RESET = 1'b1
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic [DW-1:0] ram_d,
    input  logic [AW-1:0] ram_ad,
    input  logic          ram_cs,
    input  logic          ram_we,
    input  logic [DW-1:0] ram_d_b,
    input  logic [AW-1:0] ram_ad_b,
    input  logic          ram_we_b,
    output logic [DW-1:0] ram_q,
    output logic          busy,
    output logic          busy_b,
    output logic          ack_b
`ifdef RAM_COLLIDE_EN
    ,
    output logic [7:0]    collide_cnt
`endif
);

    ram_state_t    state;
    logic [AW-1:0] clr_addr;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_data;

    logic          a_wr;
    logic          in_run;
    logic          b_commit;
    logic          b_defer;
    logic          b_drop;

    logic          core_we;
    logic          core_re;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;

    assign a_wr     = ram_cs & ram_we;
    assign in_run   = (state == ST_RUN);
    // Port B owns the array slot this cycle: either the buffered word or a fresh strobe.
    assign b_commit = in_run & ~a_wr & (busy_b | ram_we_b);
    assign b_defer  = in_run & a_wr & ram_we_b & ~busy_b;
    assign b_drop   = in_run & ram_we_b & busy_b;

    // Arbiter: pick the single array access for this cycle.
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    always_comb begin
        core_we    = 1'b0;
        core_re    = 1'b0;
        core_addr  = ram_ad;
        core_wdata = ram_d;
        if (!in_run) begin
            core_we    = 1'b1;
            core_addr  = clr_addr;
            core_wdata = CLR_VAL;
        end else if (a_wr) begin
            core_we    = 1'b1;
        end else if (busy_b) begin
            core_we    = 1'b1;
            core_addr  = buf_addr;
            core_wdata = buf_data;
        end else if (ram_we_b) begin
            core_we    = 1'b1;
            core_addr  = ram_ad_b;
            core_wdata = ram_d_b;
        end else begin
            core_re    = 1'b1;
        end
    end

    // Control FSM: clear sweep, deferral buffer and port-B acknowledge.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= CLR_ON_RESET ? ST_CLEAR : ST_RUN;
            busy     <= CLR_ON_RESET;
            clr_addr <= '0;
            busy_b   <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
            ack_b    <= 1'b0;
        end else begin
            ack_b <= b_commit;
            case (state)
                ST_CLEAR: begin
                    if (clr_addr == {AW{1'b1}}) begin
                        state <= ST_RUN;
                        busy  <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (b_defer) begin
                        busy_b   <= 1'b1;
                        buf_addr <= ram_ad_b;
                        buf_data <= ram_d_b;
                    end else if (busy_b && !a_wr) begin
                        busy_b   <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_RUN;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef RAM_COLLIDE_EN
    // Saturating count of cycles where a port-B write could not commit directly.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            collide_cnt <= '0;
        end else if ((b_defer || b_drop) && collide_cnt != 8'hFF) begin
            collide_cnt <= collide_cnt + 8'd1;
        end
    end
`endif

    oric_ram_core #(
        .AW (AW),
        .DW (DW)
    ) u_core (
        .clk_sys (clk_sys),
        .reset   (reset),
        .we      (core_we),
        .re      (core_re),
        .addr    (core_addr),
        .wdata   (core_wdata),
        .ld      (~in_run),
        .ld_val  (CLR_VAL),
        .rdata   (ram_q)
    );

endmodule

// File: tb/tb_oric_ram_arb.sv
// Directed bench for oric_ram_arb: an AW=4 instance for short clears and an
// AW=16 instance for one full-size clear. Build with RAM_COLLIDE_EN defined
// to also cover collide_cnt.
module tb_oric_ram_arb;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic [7:0] ram_d;
    logic [3:0] ram_ad;
    logic       ram_cs;
    logic       ram_we;
    logic [7:0] ram_d_b;
    logic [3:0] ram_ad_b;
    logic       ram_we_b;
    logic [7:0] ram_q;
    logic       busy;
    logic       busy_b;
    logic       ack_b;
`ifdef RAM_COLLIDE_EN
    logic [7:0] collide_cnt;
    logic [7:0] collide_cnt16;
`endif

    logic        reset16;
    logic [15:0] ram_ad16;
    logic [7:0]  ram_q16;
    logic        busy16;
    logic        busy_b16;
    logic        ack_b16;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_sys = ~clk_sys;

    oric_ram_arb #(.AW(4), .DW(8), .CLR_VAL(8'hFF), .CLR_ON_RESET(1'b1)) u_dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ram_d    (ram_d),
        .ram_ad   (ram_ad),
        .ram_cs   (ram_cs),
        .ram_we   (ram_we),
        .ram_d_b  (ram_d_b),
        .ram_ad_b (ram_ad_b),
        .ram_we_b (ram_we_b),
        .ram_q    (ram_q),
        .busy     (busy),
        .busy_b   (busy_b),
        .ack_b    (ack_b)
`ifdef RAM_COLLIDE_EN
        ,
        .collide_cnt (collide_cnt)
`endif
    );

    oric_ram_arb #(.AW(16), .DW(8), .CLR_VAL(8'hFF), .CLR_ON_RESET(1'b1)) u_dut16 (
        .clk_sys  (clk_sys),
        .reset    (reset16),
        .ram_d    (8'h00),
        .ram_ad   (ram_ad16),
        .ram_cs   (1'b0),
        .ram_we   (1'b0),
        .ram_d_b  (8'h00),
        .ram_ad_b (16'h0000),
        .ram_we_b (1'b0),
        .ram_q    (ram_q16),
        .busy     (busy16),
        .busy_b   (busy_b16),
        .ack_b    (ack_b16)
`ifdef RAM_COLLIDE_EN
        ,
        .collide_cnt (collide_cnt16)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are looked at 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle_a();
        ram_cs   = 1'b0;
        ram_we   = 1'b0;
        ram_we_b = 1'b0;
    endtask

    initial begin
        int  n;
        logic seen_ack;
        logic seen_bb;

        reset    = 1'b1;
        reset16  = 1'b1;
        ram_d    = 8'h00;
        ram_ad   = 4'h0;
        ram_d_b  = 8'h00;
        ram_ad_b = 4'h0;
        ram_ad16 = 16'h0000;
        idle_a();

        // 1. Reset state and clear duration.
        tick();
        reset = 1'b0;
        check("rst_busy",   32'(busy),   32'd1);
        check("rst_ram_q",  32'(ram_q),  32'h00);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        check("rst_ack_b",  32'(ack_b),  32'd0);
`ifdef RAM_COLLIDE_EN
        check("rst_collide", 32'(collide_cnt), 32'd0);
`endif
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
            if (n == 1) check("clr_ram_q", 32'(ram_q), 32'hFF);
        end
        check("clr_cycles", 32'(n), 32'd16);
        for (int a = 0; a < 16; a++) begin
            ram_ad = 4'(a);
            tick();
            check($sformatf("clr_rd%0d", a), 32'(ram_q), 32'hFF);
        end

        // 2. Reset part-way through the clear restarts it; port writes are ignored.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (7) tick();
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        ram_cs   = 1'b1;
        ram_we   = 1'b1;
        ram_ad   = 4'h0;
        ram_d    = 8'h12;
        ram_we_b = 1'b1;
        ram_ad_b = 4'h1;
        ram_d_b  = 8'h34;
        seen_ack = 1'b0;
        seen_bb  = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
            seen_ack |= ack_b;
            seen_bb  |= busy_b;
        end
        idle_a();
        check("reclr_cycles", 32'(n), 32'd16);
        check("reclr_noack",  32'(seen_ack), 32'd0);
        check("reclr_nobb",   32'(seen_bb),  32'd0);
        ram_ad = 4'h0;
        tick();
        check("reclr_rd0", 32'(ram_q), 32'hFF);
        ram_ad = 4'h1;
        tick();
        check("reclr_rd1", 32'(ram_q), 32'hFF);

        // 3. Port A write then read: one-cycle read latency, ram_q held during the write.
        ram_cs = 1'b1;
        ram_we = 1'b1;
        ram_ad = 4'h3;
        ram_d  = 8'h5A;
        tick();
        check("wr_hold_q", 32'(ram_q), 32'hFF);
        idle_a();
        tick();
        check("rd_lat", 32'(ram_q), 32'h5A);

        // Uncontested port-B write commits at once with an ack pulse.
        ram_we_b = 1'b1;
        ram_ad_b = 4'h8;
        ram_d_b  = 8'h77;
        tick();
        check("b_ack",    32'(ack_b),  32'd1);
        check("b_nobusy", 32'(busy_b), 32'd0);
        idle_a();
        ram_ad = 4'h8;
        tick();
        check("b_rd",      32'(ram_q), 32'h77);
        check("b_ack_end", 32'(ack_b), 32'd0);

        // 4/5. Collision at ad=2 (B deferred), then a B strobe while busy_b (dropped).
        ram_cs   = 1'b1;
        ram_we   = 1'b1;
        ram_ad   = 4'h2;
        ram_d    = 8'h11;
        ram_we_b = 1'b1;
        ram_ad_b = 4'h2;
        ram_d_b  = 8'h22;
        tick();
        check("col_busy_b", 32'(busy_b), 32'd1);
        check("col_ack0",   32'(ack_b),  32'd0);
        ram_cs   = 1'b0;
        ram_we   = 1'b0;
        ram_ad_b = 4'h4;
        ram_d_b  = 8'h33;
        tick();
        check("col_busy_b_fall", 32'(busy_b), 32'd0);
        check("col_ack1",        32'(ack_b),  32'd1);
        idle_a();
        ram_ad = 4'h2;
        tick();
        check("col_ack_end", 32'(ack_b), 32'd0);
        check("col_rd2",     32'(ram_q), 32'h22);
        ram_ad = 4'h4;
        tick();
        check("drop_rd4", 32'(ram_q), 32'hFF);
`ifdef RAM_COLLIDE_EN
        check("drop_collide", 32'(collide_cnt), 32'd2);
`endif

        // 6. Buffer full while port A writes five more cycles; commit in cycle 6.
        ram_cs   = 1'b1;
        ram_we   = 1'b1;
        ram_ad   = 4'h5;
        ram_d    = 8'hA0;
        ram_we_b = 1'b1;
        ram_ad_b = 4'h6;
        ram_d_b  = 8'h66;
        tick();
        ram_we_b = 1'b0;
        check("hold_busy_b0", 32'(busy_b), 32'd1);
        for (int k = 0; k < 5; k++) begin
            ram_ad = 4'(9 + k);
            ram_d  = 8'(8'hB0 + k);
            tick();
            check($sformatf("hold_ack%0d", k),    32'(ack_b),  32'd0);
            check($sformatf("hold_busy_b%0d", k), 32'(busy_b), 32'd1);
        end
        idle_a();
        tick();
        check("hold_commit_ack", 32'(ack_b),  32'd1);
        check("hold_commit_bb",  32'(busy_b), 32'd0);
        ram_ad = 4'h6;
        tick();
        check("hold_rd6", 32'(ram_q), 32'h66);
        ram_ad = 4'hB;
        tick();
        check("hold_rdB", 32'(ram_q), 32'hB2);
        ram_ad = 4'h5;
        tick();
        check("hold_rd5", 32'(ram_q), 32'hA0);
`ifdef RAM_COLLIDE_EN
        check("hold_collide", 32'(collide_cnt), 32'd3);
`endif

        // Full-size array: clear lasts exactly 65536 cycles and reaches the top word.
        tick();
        reset16 = 1'b0;
        check("big_rst_busy", 32'(busy16), 32'd1);
        n = 0;
        while (busy16 && n < 70000) begin
            tick();
            n++;
        end
        check("big_clr_cycles", 32'(n), 32'd65536);
        ram_ad16 = 16'hFFFF;
        tick();
        check("big_rd_top", 32'(ram_q16), 32'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
